// File: rtl/rvfi_pkg.sv
// rvfi_pkg: types and helpers shared by the RVFI commit tracker.
//   rvfi_pkt_t   - one in-flight monitor packet (valid plus every RVFI field)
//   RVFI_XLEN    - data/address width of the packet fields
//   MASK_W       - byte-mask width for mem_rmask / mem_wmask
//   merge_mem    - overlays memory-stage fields onto a packet
//   is_self_loop - true when an instruction jumps to itself (halt idiom)
package rvfi_pkg;

  localparam int RVFI_XLEN = 32;
  localparam int MASK_W    = 4;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          inst;
    logic [RVFI_XLEN-1:0] pc_rdata;
    logic [RVFI_XLEN-1:0] pc_wdata;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [4:0]           rd_addr;
    logic [RVFI_XLEN-1:0] rs1_rdata;
    logic [RVFI_XLEN-1:0] rs2_rdata;
    logic                 trap;
    logic [RVFI_XLEN-1:0] mem_addr;
    logic [RVFI_XLEN-1:0] mem_wdata;
    logic [MASK_W-1:0]    mem_rmask;
    logic [MASK_W-1:0]    mem_wmask;
  } rvfi_pkt_t;

  function automatic rvfi_pkt_t merge_mem(
    input rvfi_pkt_t            pkt,
    input logic [RVFI_XLEN-1:0] addr,
    input logic [RVFI_XLEN-1:0] wdata,
    input logic [MASK_W-1:0]    rmask,
    input logic [MASK_W-1:0]    wmask
  );
    rvfi_pkt_t res;
    res           = pkt;
    res.mem_addr  = addr;
    res.mem_wdata = wdata;
    res.mem_rmask = rmask;
    res.mem_wmask = wmask;
    return res;
  endfunction

  function automatic logic is_self_loop(
    input logic [RVFI_XLEN-1:0] pc_rdata,
    input logic [RVFI_XLEN-1:0] pc_wdata
  );
    return (pc_rdata == pc_wdata);
  endfunction

endpackage

// File: rtl/rvfi_stage_reg.sv
// rvfi_stage_reg: one shadow-pipeline packet register.
//   clk, rst - clock, synchronous active-high reset (clears the whole packet)
//   stall    - hold the current packet
//   flush    - drop the packet (valid cleared); wins over stall
//   d        - packet loaded when neither stall nor flush is active
//   q        - registered packet
module rvfi_stage_reg
  import rvfi_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      stall,
  input  logic      flush,
  input  rvfi_pkt_t d,
  output rvfi_pkt_t q
);

  rvfi_pkt_t q_r;
  logic      load_s;

  assign load_s = !stall;

  // Packet register: flush kills only valid so stale fields are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (flush) begin
      q_r.valid <= 1'b0;
    end else if (load_s) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/rvfi_commit_tracker.sv
// rvfi_commit_tracker: carries one RVFI packet per in-flight instruction through
// a STAGES-deep shadow pipeline mirroring the datapath's stall/flush behaviour.
//   clk, rst            - clock, synchronous active-high reset
//   stall, flush        - whole-pipeline hold, per-stage kill (flush wins)
//   in_*                - decode-time fields entering stage 0 when in_valid
//   mem_*               - memory fields captured as a packet enters MEM_STAGE
//   wb_*                - final-stage data, passed straight to the outputs
//   rvfi_*              - commit, order, halt and packet fields of the last stage
//   halted, watchdog    - sticky halt flag, sticky commit-gap timeout flag
// XLEN must match rvfi_pkg::RVFI_XLEN (packet fields are sized by the package).
module rvfi_commit_tracker
  import rvfi_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STAGES    = 4,
  parameter int MEM_STAGE = 2,
  parameter int ORDER_W   = 64,
  parameter int TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [STAGES-1:0]  flush,
  input  logic               in_valid,
  input  logic [31:0]        in_inst,
  input  logic [XLEN-1:0]    in_pc_rdata,
  input  logic [XLEN-1:0]    in_pc_wdata,
  input  logic [4:0]         in_rs1_addr,
  input  logic [4:0]         in_rs2_addr,
  input  logic [4:0]         in_rd_addr,
  input  logic [XLEN-1:0]    in_rs1_rdata,
  input  logic [XLEN-1:0]    in_rs2_rdata,
  input  logic               in_trap,
  input  logic [XLEN-1:0]    mem_addr,
  input  logic [XLEN-1:0]    mem_wdata,
  input  logic [MASK_W-1:0]  mem_rmask,
  input  logic [MASK_W-1:0]  mem_wmask,
  input  logic [XLEN-1:0]    wb_rd_wdata,
  input  logic [XLEN-1:0]    wb_mem_rdata,
  output logic               rvfi_commit,
  output logic [ORDER_W-1:0] rvfi_order,
  output logic               rvfi_halt,
  output logic [31:0]        rvfi_inst,
  output logic [XLEN-1:0]    rvfi_pc_rdata,
  output logic [XLEN-1:0]    rvfi_pc_wdata,
  output logic [4:0]         rvfi_rs1_addr,
  output logic [4:0]         rvfi_rs2_addr,
  output logic [4:0]         rvfi_rd_addr,
  output logic [XLEN-1:0]    rvfi_rs1_rdata,
  output logic [XLEN-1:0]    rvfi_rs2_rdata,
  output logic [XLEN-1:0]    rvfi_rd_wdata,
  output logic               rvfi_trap,
  output logic [XLEN-1:0]    rvfi_mem_addr,
  output logic [XLEN-1:0]    rvfi_mem_wdata,
  output logic [MASK_W-1:0]  rvfi_mem_rmask,
  output logic [MASK_W-1:0]  rvfi_mem_wmask,
  output logic [XLEN-1:0]    rvfi_mem_rdata,
  output logic               halted,
  output logic               watchdog
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_TOP = WD_W'(TIMEOUT);

  rvfi_pkt_t stage_d_s [STAGES];
  rvfi_pkt_t stage_q_s [STAGES];
  rvfi_pkt_t tail_s;

  logic               commit_s;
  logic               halt_s;
  logic [ORDER_W-1:0] order_r;
  logic               halted_r;
  logic [WD_W-1:0]    wd_cnt_r;
  logic [WD_W-1:0]    wd_cnt_nxt_s;
  logic               watchdog_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_entry
      // in_valid needs no stall gating: the stage register holds while stalled.
      assign stage_d_s[k] = '{
        valid:     in_valid,
        inst:      in_inst,
        pc_rdata:  in_pc_rdata,
        pc_wdata:  in_pc_wdata,
        rs1_addr:  in_rs1_addr,
        rs2_addr:  in_rs2_addr,
        rd_addr:   in_rd_addr,
        rs1_rdata: in_rs1_rdata,
        rs2_rdata: in_rs2_rdata,
        trap:      in_trap,
        mem_addr:  '0,
        mem_wdata: '0,
        mem_rmask: '0,
        mem_wmask: '0
      };
    end else if (k == MEM_STAGE) begin : g_mem
      assign stage_d_s[k] = merge_mem(stage_q_s[k-1], mem_addr, mem_wdata,
                                      mem_rmask, mem_wmask);
    end else begin : g_pass
      assign stage_d_s[k] = stage_q_s[k-1];
    end

    rvfi_stage_reg u_stage (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .flush (flush[k]),
      .d     (stage_d_s[k]),
      .q     (stage_q_s[k])
    );
  end

  assign tail_s   = stage_q_s[STAGES-1];
  // The reset cycle never retires anything, even if the tail is still valid.
  assign commit_s = tail_s.valid && !stall && !flush[STAGES-1] && !rst;
  assign halt_s   = commit_s && is_self_loop(tail_s.pc_rdata, tail_s.pc_wdata);

  // Retirement order counter, wraps naturally at 2^ORDER_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      order_r <= '0;
    end else if (commit_s) begin
      order_r <= order_r + ORDER_W'(1);
    end else begin
      order_r <= order_r;
    end
  end

  // Sticky halt, set the cycle after a self-loop retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_r <= 1'b0;
    end else if (halt_s) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  // Next watchdog count: cleared by a commit, frozen once halted, saturating.
  always_comb begin
    wd_cnt_nxt_s = wd_cnt_r;
    if (commit_s) begin
      wd_cnt_nxt_s = '0;
    end else if (halted_r) begin
      wd_cnt_nxt_s = wd_cnt_r;
    end else if (wd_cnt_r != WD_TOP) begin
      wd_cnt_nxt_s = wd_cnt_r + WD_W'(1);
    end else begin
      wd_cnt_nxt_s = wd_cnt_r;
    end
  end

  // Watchdog counter and its sticky flag (raised as the count lands on TIMEOUT).
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r   <= '0;
      watchdog_r <= 1'b0;
    end else begin
      wd_cnt_r <= wd_cnt_nxt_s;
      if (wd_cnt_nxt_s == WD_TOP) begin
        watchdog_r <= 1'b1;
      end else begin
        watchdog_r <= watchdog_r;
      end
    end
  end

  assign rvfi_commit    = commit_s;
  assign rvfi_order     = order_r;
  assign rvfi_halt      = halt_s;
  assign rvfi_inst      = tail_s.inst;
  assign rvfi_pc_rdata  = tail_s.pc_rdata;
  assign rvfi_pc_wdata  = tail_s.pc_wdata;
  assign rvfi_rs1_addr  = tail_s.rs1_addr;
  assign rvfi_rs2_addr  = tail_s.rs2_addr;
  assign rvfi_rd_addr   = tail_s.rd_addr;
  assign rvfi_rs1_rdata = tail_s.rs1_rdata;
  assign rvfi_rs2_rdata = tail_s.rs2_rdata;
  // x0 writes are architecturally invisible, so report zero for them.
  assign rvfi_rd_wdata  = (tail_s.rd_addr != 5'd0) ? wb_rd_wdata : {XLEN{1'b0}};
  assign rvfi_trap      = tail_s.trap;
  assign rvfi_mem_addr  = tail_s.mem_addr;
  assign rvfi_mem_wdata = tail_s.mem_wdata;
  assign rvfi_mem_rmask = tail_s.mem_rmask;
  assign rvfi_mem_wmask = tail_s.mem_wmask;
  assign rvfi_mem_rdata = wb_mem_rdata;
  assign halted         = halted_r;
  assign watchdog       = watchdog_r;

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Scoreboard bench: the driver advances a queue-of-slots reference model each
// cycle and pushes the expected output record; a negedge monitor pops and compares.
module tb_rvfi_commit_tracker;

  localparam int S  = 4;
  localparam int MS = 2;
  localparam int OW = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, stall, in_valid, in_trap;
  logic [S-1:0]  flush;
  logic [31:0]   in_inst, in_pc_rdata, in_pc_wdata, in_rs1_rdata, in_rs2_rdata;
  logic [4:0]    in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0]   mem_addr, mem_wdata, wb_rd_wdata, wb_mem_rdata;
  logic [3:0]    mem_rmask, mem_wmask;
  logic          rvfi_commit, rvfi_halt, rvfi_trap, halted, watchdog;
  logic [OW-1:0] rvfi_order;
  logic [31:0]   rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
  logic [31:0]   rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rdata;
  logic [4:0]    rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [3:0]    rvfi_mem_rmask, rvfi_mem_wmask;

  always #5 clk = ~clk;

  rvfi_commit_tracker #(.XLEN(32), .STAGES(S), .MEM_STAGE(MS), .ORDER_W(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_inst(in_inst), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_rdata(in_rs1_rdata), .in_rs2_rdata(in_rs2_rdata), .in_trap(in_trap),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .wb_rd_wdata(wb_rd_wdata), .wb_mem_rdata(wb_mem_rdata),
    .rvfi_commit(rvfi_commit), .rvfi_order(rvfi_order), .rvfi_halt(rvfi_halt),
    .rvfi_inst(rvfi_inst), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .halted(halted), .watchdog(watchdog)
  );

  typedef struct {
    logic [31:0] inst, pcr, pcw, rs1d, rs2d, maddr, mwdata;
    logic [4:0]  rs1a, rs2a, rda;
    logic        trap;
    logic [3:0]  mrmask, mwmask;
  } txn_t;

  typedef struct {
    bit          chk;
    bit          commit;
    logic [63:0] order;
    bit          halt, halted, wd;
    logic [31:0] wbr, wbm;
    txn_t        p;
  } exp_t;

  exp_t        exp_q[$];
  txn_t        tx[$];
  int          slot[S];
  logic [63:0] m_order;
  bit          m_halted, m_wd;
  int          m_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  // next-cycle stimulus
  bit          d_rst, d_stall, d_iv;
  logic [S-1:0] d_flush;
  txn_t        d_pkt;
  logic [31:0] d_maddr, d_mwdata, d_wbr, d_wbm;
  logic [3:0]  d_mrm, d_mwm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] pcr, input logic [31:0] pcw, input logic [4:0] rd);
    txn_t t;
    t.inst = $urandom; t.pcr = pcr; t.pcw = pcw;
    t.rs1a = 5'($urandom); t.rs2a = 5'($urandom); t.rda = rd;
    t.rs1d = $urandom; t.rs2d = $urandom; t.trap = 1'($urandom);
    t.maddr = 32'd0; t.mwdata = 32'd0; t.mrmask = 4'd0; t.mwmask = 4'd0;
    return t;
  endfunction

  task automatic idle();
    logic [31:0] pc;
    pc = 32'($urandom) & 32'hFFFF_FFFC;
    d_rst = 1'b0; d_stall = 1'b0; d_flush = '0; d_iv = 1'b0;
    d_pkt = mk(pc, pc + 32'd4, 5'($urandom));
    d_maddr = $urandom; d_mwdata = $urandom; d_mrm = 4'($urandom); d_mwm = 4'($urandom);
    d_wbr = $urandom; d_wbm = $urandom;
  endtask

  task automatic issue(input logic [31:0] pcr, input logic [31:0] pcw, input logic [4:0] rd);
    idle();
    d_iv = 1'b1;
    d_pkt = mk(pcr, pcw, rd);
  endtask

  // Drive one cycle, push its expected outputs, advance the reference model.
  task automatic step();
    exp_t e;
    int   ns[S];
    @(posedge clk);
    #1;
    rst = d_rst; stall = d_stall; flush = d_flush; in_valid = d_iv;
    in_inst = d_pkt.inst; in_pc_rdata = d_pkt.pcr; in_pc_wdata = d_pkt.pcw;
    in_rs1_addr = d_pkt.rs1a; in_rs2_addr = d_pkt.rs2a; in_rd_addr = d_pkt.rda;
    in_rs1_rdata = d_pkt.rs1d; in_rs2_rdata = d_pkt.rs2d; in_trap = d_pkt.trap;
    mem_addr = d_maddr; mem_wdata = d_mwdata; mem_rmask = d_mrm; mem_wmask = d_mwm;
    wb_rd_wdata = d_wbr; wb_mem_rdata = d_wbm;

    e.chk    = !d_rst;
    e.commit = !d_rst && (slot[S-1] >= 0) && !d_stall && !d_flush[S-1];
    e.p      = e.commit ? tx[slot[S-1]] : d_pkt;
    e.order  = m_order;
    e.halt   = e.commit && (e.p.pcr == e.p.pcw);
    e.halted = m_halted;
    e.wd     = m_wd;
    e.wbr    = d_wbr;
    e.wbm    = d_wbm;
    exp_q.push_back(e);

    if (d_rst) begin
      for (int k = 0; k < S; k++) slot[k] = -1;
      m_order = 64'd0; m_halted = 1'b0; m_cnt = 0; m_wd = 1'b0;
    end else begin
      if (e.commit) begin
        m_order = m_order + 64'd1;
        m_cnt = 0;
      end else if (!m_halted && m_cnt < TO) begin
        m_cnt++;
        if (m_cnt == TO) m_wd = 1'b1;
      end
      if (e.halt) m_halted = 1'b1;
      for (int k = 0; k < S; k++) begin
        if (d_flush[k]) ns[k] = -1;
        else if (d_stall) ns[k] = slot[k];
        else if (k == 0) begin
          if (d_iv) begin
            tx.push_back(d_pkt);
            ns[k] = tx.size() - 1;
          end else ns[k] = -1;
        end else begin
          ns[k] = slot[k-1];
          if (k == MS && slot[k-1] >= 0) begin
            tx[slot[k-1]].maddr  = d_maddr;
            tx[slot[k-1]].mwdata = d_mwdata;
            tx[slot[k-1]].mrmask = d_mrm;
            tx[slot[k-1]].mwmask = d_mwm;
          end
        end
      end
      for (int k = 0; k < S; k++) slot[k] = ns[k];
    end
  endtask

  // Monitor: one expected record per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("commit", 64'(rvfi_commit), 64'(e.commit));
      if (e.chk) begin
        chk("order", rvfi_order, e.order);
        chk("halt", 64'(rvfi_halt), 64'(e.halt));
        chk("halted", 64'(halted), 64'(e.halted));
        chk("watchdog", 64'(watchdog), 64'(e.wd));
        chk("mem_rdata", 64'(rvfi_mem_rdata), 64'(e.wbm));
      end
      if (e.commit) begin
        chk("inst", 64'(rvfi_inst), 64'(e.p.inst));
        chk("pc_rdata", 64'(rvfi_pc_rdata), 64'(e.p.pcr));
        chk("pc_wdata", 64'(rvfi_pc_wdata), 64'(e.p.pcw));
        chk("rs1_addr", 64'(rvfi_rs1_addr), 64'(e.p.rs1a));
        chk("rs2_addr", 64'(rvfi_rs2_addr), 64'(e.p.rs2a));
        chk("rd_addr", 64'(rvfi_rd_addr), 64'(e.p.rda));
        chk("rs1_rdata", 64'(rvfi_rs1_rdata), 64'(e.p.rs1d));
        chk("rs2_rdata", 64'(rvfi_rs2_rdata), 64'(e.p.rs2d));
        chk("trap", 64'(rvfi_trap), 64'(e.p.trap));
        chk("mem_addr", 64'(rvfi_mem_addr), 64'(e.p.maddr));
        chk("mem_wdata", 64'(rvfi_mem_wdata), 64'(e.p.mwdata));
        chk("mem_rmask", 64'(rvfi_mem_rmask), 64'(e.p.mrmask));
        chk("mem_wmask", 64'(rvfi_mem_wmask), 64'(e.p.mwmask));
        chk("rd_wdata", 64'(rvfi_rd_wdata), (e.p.rda != 5'd0) ? 64'(e.wbr) : 64'd0);
      end
    end
  end

  initial begin
    for (int k = 0; k < S; k++) slot[k] = -1;
    m_order = 64'd0; m_halted = 1'b0; m_wd = 1'b0; m_cnt = 0;
    idle();
    rst = 1'b1; stall = 1'b0; flush = '0; in_valid = 1'b0;
    in_inst = '0; in_pc_rdata = '0; in_pc_wdata = '0; in_rs1_addr = '0; in_rs2_addr = '0;
    in_rd_addr = '0; in_rs1_rdata = '0; in_rs2_rdata = '0; in_trap = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_rmask = '0; mem_wmask = '0;
    wb_rd_wdata = '0; wb_mem_rdata = '0;
    repeat (2) @(posedge clk);

    // idle from reset: watchdog must rise in cycle TO and stay
    for (int i = 0; i < TO + 4; i++) begin idle(); step(); end
    idle(); d_rst = 1'b1; step();

    // three back-to-back instructions, first writes x0
    issue(32'h60, 32'h64, 5'd0); step();
    issue(32'h64, 32'h68, 5'd5); step();
    issue(32'h68, 32'h6C, 5'd7); step();
    for (int i = 0; i < 5; i++) begin idle(); step(); end

    // two-cycle stall while the instruction sits in stage 1
    issue(32'h200, 32'h204, 5'd3); step();
    idle(); step();
    idle(); d_stall = 1'b1; step();
    idle(); d_stall = 1'b1; step();
    for (int i = 0; i < 5; i++) begin idle(); step(); end

    // flush stages 0 and 1, then one more instruction gets the next order
    issue(32'h300, 32'h304, 5'd1); step();
    issue(32'h304, 32'h308, 5'd2); step();
    idle(); d_flush = 4'b0011; step();
    issue(32'h308, 32'h30C, 5'd4); step();
    for (int i = 0; i < 5; i++) begin idle(); step(); end

    // stall with flush[2]; stages 0,1,3 hold, new in_valid ignored
    for (int i = 0; i < 4; i++) begin issue(32'h400 + 32'(4 * i), 32'h404 + 32'(4 * i), 5'd9); step(); end
    issue(32'h500, 32'h504, 5'd9); d_stall = 1'b1; d_flush = 4'b0100; step();
    for (int i = 0; i < 6; i++) begin idle(); step(); end

    // store captured at MEM_STAGE
    issue(32'h600, 32'h604, 5'd0); step();
    idle(); step();
    idle(); d_maddr = 32'h100; d_mwm = 4'b0011; d_mrm = 4'b0000; step();
    for (int i = 0; i < 4; i++) begin idle(); step(); end
    // same store killed as it enters MEM_STAGE
    issue(32'h610, 32'h614, 5'd0); step();
    idle(); step();
    idle(); d_maddr = 32'h100; d_mwm = 4'b0011; d_flush = 4'b0100; step();
    for (int i = 0; i < 4; i++) begin idle(); step(); end

    // self-loop commit: halt pulse then sticky halted
    issue(32'h80, 32'h80, 5'd0); step();
    for (int i = 0; i < 6; i++) begin idle(); step(); end
    issue(32'h84, 32'h88, 5'd6); step();
    for (int i = 0; i < 5; i++) begin idle(); step(); end

    // reset with the pipeline full, in the cycle the oldest would commit
    for (int i = 0; i < 4; i++) begin issue(32'h700 + 32'(4 * i), 32'h704 + 32'(4 * i), 5'd8); step(); end
    idle(); d_rst = 1'b1; step();
    for (int i = 0; i < 6; i++) begin idle(); step(); end

    // randomized traffic
    for (int i = 0; i < 900; i++) begin
      logic [31:0] pc;
      pc = 32'($urandom) & 32'hFFFF_FFFC;
      idle();
      if ($urandom_range(0, 3) != 0)
        issue(pc, ($urandom_range(0, 11) == 0) ? pc : pc + 32'd4, 5'($urandom_range(0, 7)));
      d_stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) d_flush = 4'($urandom);
      if ($urandom_range(0, 299) == 0) d_rst = 1'b1;
      step();
    end
    for (int i = 0; i < 6; i++) begin idle(); step(); end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
